// File: rtl/rdma_rd_credit_gate.sv
// rdma_rd_credit_gate
// Credit gate between the request parser and the RDMA stack. READ requests
// consume one credit when accepted and return it on rd_done; every other
// opcode passes freely. A single-entry output register keeps order strictly,
// so a READ waiting for credit also holds back every younger request.
//
// Handshake (both s_req and m_req): a transfer happens on the rising edge of
// aclk where valid && ready are both 1. valid may not depend on ready; ready
// may depend on valid's payload (s_req_ready looks at the head opcode).
//
// The rdma_req_t request struct is carried flattened as an REQ_W-bit vector.
// Its opcode field sits at bit OPC_LSB and is 5 bits wide.
module rdma_rd_credit_gate #(
  parameter int         N_RD_CREDITS = 16,
  parameter int         CNT_BITS     = $clog2(N_RD_CREDITS + 1),
  parameter int         REQ_W        = 64,
  parameter int         OPC_LSB      = 0,
  parameter logic [4:0] RD_OPCODE    = 5'h0C   // RC_RDMA_READ_REQUEST
) (
  input  logic                aclk,
  input  logic                aresetn,
  // request stream from the parser
  input  logic                s_req_valid,
  output logic                s_req_ready,
  input  logic [REQ_W-1:0]    s_req_data,
  // credit-gated request stream to the RDMA stack
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [REQ_W-1:0]    m_req_data,
  // credit return and status
  input  logic                rd_done,
  output logic [CNT_BITS-1:0] rd_outstanding,
  output logic [31:0]         stall_cnt,
  output logic                err_underflow,
  // output-stage FSM state: 0 = ST_EMPTY, 1 = ST_FULL
  output logic                dbg_state
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(N_RD_CREDITS);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [REQ_W-1:0]    r_data;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic [31:0]         r_stall;
  logic                r_err;

  logic w_is_read;
  logic w_credit_ok;
  logic w_slot_free;
  logic w_accept;
  logic w_rd_accept;
  logic w_underflow;
  logic w_stall;

  // Head request classification and the accept decision. ready is forced low
  // while reset is asserted so nothing can be taken during reset.
  assign w_is_read   = (s_req_data[OPC_LSB +: 5] == RD_OPCODE);
  assign w_credit_ok = !w_is_read || (r_cnt < MAX_CNT);
  assign w_slot_free = (r_state == ST_EMPTY) || m_req_ready;
  assign s_req_ready = aresetn && w_slot_free && w_credit_ok;
  assign w_accept    = s_req_valid && s_req_ready;
  assign w_rd_accept = w_accept && w_is_read;
  assign w_stall     = s_req_valid && w_is_read && (r_cnt == MAX_CNT);

  assign m_req_valid    = (r_state == ST_FULL);
  assign m_req_data     = r_data;
  assign rd_outstanding = r_cnt;
  assign stall_cnt      = r_stall;
  assign err_underflow  = r_err;
  assign dbg_state      = (r_state == ST_FULL);

  // Output-stage FSM next state: fill on accept, drain on egress without refill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (m_req_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output-stage state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // Output payload register: loaded only on accept, so it holds under backpressure.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)      r_data <= '0;
    else if (w_accept) r_data <= s_req_data;
  end

  // Credit counter next value. A read accept and a credit return in the same
  // cycle cancel out, which also covers a return arriving at zero alongside a
  // read accept. A lone return at zero is an underflow and leaves the count.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_underflow = 1'b0;
    case ({w_rd_accept, rd_done})
      2'b10: w_cnt_nxt = r_cnt + CNT_ONE;
      2'b01: begin
        if (r_cnt == '0) w_underflow = 1'b1;
        else             w_cnt_nxt   = r_cnt - CNT_ONE;
      end
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Outstanding-read counter; a returned credit is only seen by the accept
  // logic from the following cycle on.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end

  // Cycles a head READ spent blocked on credit; wraps naturally at 2^32.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     r_stall <= '0;
    else if (w_stall) r_stall <= r_stall + 32'd1;
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)         r_err <= 1'b0;
    else if (w_underflow) r_err <= 1'b1;
  end

endmodule

// File: tb/tb_rdma_rd_credit_gate.sv
// Bench for rdma_rd_credit_gate with two credits. A negedge monitor keeps a
// small model of the credit count, output-stage occupancy, stall counter and
// underflow flag, checks the DUT against it every cycle, pushes accepted
// requests into exp_q and compares the egress payload against its head.
module tb_rdma_rd_credit_gate;

  localparam int         W   = 32;
  localparam int         N   = 2;
  localparam int         CB  = $clog2(N + 1);
  localparam logic [4:0] OP_RD = 5'h0C;  // RC_RDMA_READ_REQUEST
  localparam logic [4:0] OP_WM = 5'h07;  // RC_RDMA_WRITE_MIDDLE
  localparam logic [4:0] OP_WO = 5'h0A;  // RC_RDMA_WRITE_ONLY

  // clock / reset
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          s_req_valid = 1'b0;
  logic          s_req_ready;
  logic [W-1:0]  s_req_data  = '0;
  logic          m_req_valid;
  logic          m_req_ready = 1'b0;
  logic [W-1:0]  m_req_data;
  logic          rd_done     = 1'b0;
  logic [CB-1:0] rd_outstanding;
  logic [31:0]   stall_cnt;
  logic          err_underflow;
  logic          dbg_state;

  rdma_rd_credit_gate #(
    .N_RD_CREDITS (N),
    .REQ_W        (W)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_req_valid    (s_req_valid),
    .s_req_ready    (s_req_ready),
    .s_req_data     (s_req_data),
    .m_req_valid    (m_req_valid),
    .m_req_ready    (m_req_ready),
    .m_req_data     (m_req_data),
    .rd_done        (rd_done),
    .rd_outstanding (rd_outstanding),
    .stall_cnt      (stall_cnt),
    .err_underflow  (err_underflow),
    .dbg_state      (dbg_state)
  );

  // scoreboard and model state
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  int           m_cnt   = 0;
  int           m_stall = 0;
  logic         m_full  = 1'b0;
  logic         m_err   = 1'b0;
  logic         run_mon = 1'b0;
  logic         last_acc = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [4:0] op);
    logic [W-6:0] hi;
    hi = (W-5)'($urandom());
    return {hi, op};
  endfunction

  // Monitor: compare against the model, then advance the model by the
  // handshakes that the coming rising edge will perform.
  always @(negedge aclk) begin : mon
    logic exp_rdy;
    logic acc;
    logic head_rd;
    if (run_mon) begin
      head_rd = (s_req_data[4:0] == OP_RD);
      exp_rdy = (!m_full || m_req_ready) && (!head_rd || (m_cnt < N));
      check_val("s_ready",  s_req_ready, exp_rdy);
      check_val("m_valid",  m_req_valid, m_full);
      check_val("state",    dbg_state, m_full);
      check_val("rd_out",   rd_outstanding, 64'(m_cnt));
      check_val("stall",    stall_cnt, 64'(m_stall));
      check_val("err_uf",   err_underflow, m_err);
      if (m_full) begin
        check_val("q_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check_val("m_data", m_req_data, exp_q[0]);
          if (m_req_ready) void'(exp_q.pop_front());
        end
      end
      acc = s_req_valid && exp_rdy;
      if (acc) exp_q.push_back(s_req_data);
      if (s_req_valid && head_rd && (m_cnt == N)) m_stall++;
      if (acc && head_rd && !rd_done) m_cnt++;
      else if (!(acc && head_rd) && rd_done) begin
        if (m_cnt == 0) m_err = 1'b1;
        else            m_cnt--;
      end
      if (acc)              m_full = 1'b1;
      else if (m_req_ready) m_full = 1'b0;
      last_acc = acc;
    end else begin
      last_acc = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_acc(input string tag, input int budget);
    int  n   = 0;
    logic got = 1'b0;
    while (n < budget && !got) begin
      tick();
      n++;
      if (last_acc) got = 1'b1;
    end
    check_val(tag, got, 1'b1);
  endtask

  task automatic send(input logic [W-1:0] d, input string tag, input int budget);
    s_req_valid = 1'b1;
    s_req_data  = d;
    wait_acc(tag, budget);
    s_req_valid = 1'b0;
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  // Asynchronous reset pulse; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    aresetn = 1'b0;
    run_mon = 1'b0;
    #1;
    check_val("rst_m_valid", m_req_valid, 1'b0);
    check_val("rst_m_data",  m_req_data, '0);
    check_val("rst_state",   dbg_state, 1'b0);
    check_val("rst_rd_out",  rd_outstanding, '0);
    check_val("rst_stall",   stall_cnt, '0);
    check_val("rst_err",     err_underflow, 1'b0);
    check_val("rst_s_ready", s_req_ready, 1'b0);
    m_cnt = 0; m_stall = 0; m_full = 1'b0; m_err = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #3;
    aresetn = 1'b1;
    run_mon = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    pulse_reset();

    // pass-through: four back-to-back WRITE_MIDDLE
    m_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(mk(OP_WM), "pt_acc", 1);
    repeat (2) tick();
    check_val("pt_rd_out", rd_outstanding, '0);

    // credit exhaustion: two reads pass, the third waits for a credit
    send(mk(OP_RD), "rd_a", 1);
    send(mk(OP_RD), "rd_b", 1);
    s_req_valid = 1'b1;
    s_req_data  = mk(OP_RD);
    repeat (4) tick();
    check_val("rd_c_blocked", last_acc, 1'b0);
    check_val("stall_4", stall_cnt, 32'd4);
    pulse_done();
    check_val("no_bypass", last_acc, 1'b0);
    wait_acc("rd_c_acc", 1);
    s_req_valid = 1'b0;
    check_val("cnt_full", rd_outstanding, 2'd2);

    // head-of-line: blocked read, then WRITE_ONLY behind it
    s_req_valid = 1'b1;
    s_req_data  = mk(OP_RD);
    repeat (3) tick();
    pulse_done();
    wait_acc("hol_rd", 2);
    send(mk(OP_WO), "hol_wo", 2);
    repeat (2) tick();

    // simultaneous read accept and credit return at one outstanding
    pulse_done();
    check_val("sim_pre", rd_outstanding, 2'd1);
    s_req_valid = 1'b1;
    s_req_data  = mk(OP_RD);
    rd_done     = 1'b1;
    tick();
    rd_done     = 1'b0;
    s_req_valid = 1'b0;
    check_val("sim_acc", last_acc, 1'b1);
    check_val("sim_cnt", rd_outstanding, 2'd1);
    pulse_done();

    // backpressure: output held for five cycles, then released
    m_req_ready = 1'b0;
    send(mk(OP_WM), "bp_first", 1);
    s_req_valid = 1'b1;
    s_req_data  = mk(OP_WO);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_hold", last_acc, 1'b0);
    end
    m_req_ready = 1'b1;
    wait_acc("bp_go", 1);
    s_req_valid = 1'b0;
    repeat (2) tick();

    // credit return at zero together with a read accept: no underflow
    s_req_valid = 1'b1;
    s_req_data  = mk(OP_RD);
    rd_done     = 1'b1;
    tick();
    rd_done     = 1'b0;
    s_req_valid = 1'b0;
    check_val("z_acc", last_acc, 1'b1);
    check_val("z_cnt", rd_outstanding, '0);
    check_val("z_err", err_underflow, 1'b0);

    // lone credit return at zero: sticky underflow
    pulse_done();
    check_val("uf_err", err_underflow, 1'b1);
    check_val("uf_cnt", rd_outstanding, '0);
    repeat (3) tick();
    check_val("uf_sticky", err_underflow, 1'b1);

    // reset mid-transfer with a held request and an outstanding read
    m_req_ready = 1'b0;
    send(mk(OP_RD), "pre_rst", 1);
    s_req_valid = 1'b1;
    s_req_data  = mk(OP_WM);
    m_req_ready = 1'b1;
    pulse_reset();
    wait_acc("first_acc", 1);
    s_req_valid = 1'b0;

    // random traffic
    for (int i = 0; i < 80; i++) begin
      if (!s_req_valid || last_acc) begin
        s_req_valid = 1'($urandom_range(0, 1));
        s_req_data  = mk(($urandom_range(0, 1) != 0) ? OP_RD : OP_WM);
      end
      m_req_ready = ($urandom_range(0, 3) != 0);
      rd_done     = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      tick();
    end

    // drain
    s_req_valid = 1'b0;
    rd_done     = 1'b0;
    m_req_ready = 1'b1;
    repeat (3) tick();
    check_val("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rdma_rd_credit_gate.md
RDMA_RD_CREDIT_GATE -- requirements
Module: rdma_rd_credit_gate

Interface
REQ-001 The module SHALL have parameter N_RD_CREDITS, default 16, meaning the maximum number of outstanding RDMA READ requests (legal range 1..255).
REQ-002 The module SHALL have parameter CNT_BITS, default $clog2(N_RD_CREDITS+1), meaning the width of the outstanding-read counter.
REQ-003 Port aclk: input, 1 bit, the single clock; all logic is synchronous to its rising edge.
REQ-004 Port aresetn: input, 1 bit, asynchronous active-low reset.
REQ-005 Port s_req: metaIntf.s, STYPE rdma_req_t, carries per-packet requests from the request parser (one packet per transfer).
REQ-006 Port m_req: metaIntf.m, STYPE rdma_req_t, carries credit-gated per-packet requests to the RDMA stack.
REQ-007 Port rd_done: input, 1 bit, a single-cycle pulse meaning one READ request has fully completed and returns one credit.
REQ-008 Port rd_outstanding: output, CNT_BITS bits, the current number of outstanding READ requests.
REQ-009 Port stall_cnt: output, 32 bits, the number of cycles a READ request was blocked for lack of credit.
REQ-010 Port err_underflow: output, 1 bit, sticky flag set when rd_done arrives while rd_outstanding equals 0.

Function
REQ-011 A request SHALL be classified as a read iff s_req.data.opcode == RC_RDMA_READ_REQUEST; every other opcode SHALL be non-read.
REQ-012 The output stage SHALL be a single-entry register with a two-state FSM:
- ST_EMPTY: m_req.valid=0.
- ST_FULL: m_req.valid=1, and m_req.data holds the stored request.
REQ-013 credit_ok SHALL equal (rd_outstanding < N_RD_CREDITS) for read requests and SHALL be 1 for non-read requests.
REQ-014 s_req.ready SHALL equal (state==ST_EMPTY || m_req.ready) && credit_ok, evaluated combinationally from the head request.
REQ-015 The module SHALL accept a request when s_req.valid && s_req.ready; an accepted request SHALL be copied to the output register unmodified, bit for bit.
REQ-016 FSM transitions SHALL be:
- ST_EMPTY to ST_FULL on accept.
- ST_FULL to ST_EMPTY on m_req.ready with no accept.
- ST_FULL to ST_FULL on m_req.ready with accept (back-to-back, full throughput).
- Otherwise the state SHALL hold.
REQ-017 Latency from acceptance to m_req.valid SHALL be exactly 1 cycle.
REQ-018 Requests SHALL leave in acceptance order; a blocked read SHALL also block all younger requests (no bypass).
REQ-019 m_req.data SHALL remain stable while m_req.valid=1 and m_req.ready=0.
REQ-020 rd_outstanding SHALL increment by 1 on acceptance of a read request and decrement by 1 on rd_done.
REQ-021 If a read is accepted and rd_done occurs in the same cycle, rd_outstanding SHALL remain unchanged.
REQ-022 A credit returned by rd_done SHALL become usable in the following cycle; there is no same-cycle credit bypass.
REQ-023 rd_done while rd_outstanding==0 with no simultaneous read accept SHALL leave the counter at 0 and set err_underflow, which stays set until reset.
REQ-024 rd_done while rd_outstanding==0 with a simultaneous read accept SHALL leave the counter at 0 and SHALL NOT set err_underflow.
REQ-025 rd_outstanding SHALL never exceed N_RD_CREDITS.
REQ-026 stall_cnt SHALL increment in every cycle where s_req.valid=1, the head request is a read, and rd_outstanding==N_RD_CREDITS.
REQ-027 stall_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 The credit counter SHALL NOT depend on m_req.ready; credits are consumed at acceptance, not at egress.

Reset
REQ-029 While aresetn=0, the following SHALL hold, irrespective of aclk:
- state = ST_EMPTY, m_req.valid = 0, m_req.data = 0;
- rd_outstanding = 0, stall_cnt = 0, err_underflow = 0;
- s_req.ready = 0.
REQ-030 Reset asserted mid-operation SHALL discard the held request and all credit state; the first acceptance SHALL be possible in the first cycle after aresetn rises.

Verification
REQ-031 Scenario, pass-through: 4 back-to-back RC_RDMA_WRITE_MIDDLE requests with m_req.ready=1 -> 4 outputs on consecutive cycles, each 1 cycle after its input, rd_outstanding=0.
REQ-032 Scenario, credit exhaustion: N_RD_CREDITS=2, 3 reads with no rd_done -> 2 reads forwarded, s_req.ready=0 on the third, rd_outstanding=2, and stall_cnt increments every cycle; one rd_done pulse -> third read accepted on the next cycle, rd_outstanding stays 2.
REQ-033 Scenario, head-of-line blocking: a blocked read followed by a WRITE_ONLY -> WRITE_ONLY does not appear on m_req until after the read.
REQ-034 Scenario, simultaneous events: rd_outstanding=1, read accept and rd_done in the same cycle -> rd_outstanding remains 1.
REQ-035 Scenario, backpressure: m_req.ready=0 for 5 cycles with ST_FULL -> data stable and s_req.ready=0; ready=1 -> next request accepted the same cycle.
REQ-036 Scenario, reset and underflow: rd_done at rd_outstanding=0 -> err_underflow=1, counter 0; aresetn pulse low mid-transfer -> all outputs zero immediately.
